// File: rtl/mag_alarm_monitor.sv
`default_nettype none
// ============================================================================
// Module   : mag_alarm_monitor
// Purpose  : Moving-average smoothing, peak tracking and debounced hysteresis
//            alarm for an 8-bit magnitude sample stream.
// Revision : 1.0 - initial release
// ============================================================================
module mag_alarm_monitor #(
    parameter int WIN_LOG2 = 3,
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] mag_in,
    input  logic       mag_valid,
    input  logic [7:0] thresh_hi,
    input  logic [7:0] thresh_lo,
    input  logic       clear_peak,
    output logic [7:0] avg_out,
    output logic       avg_valid,
    output logic [7:0] peak_out,
    output logic       alarm,
    output logic       alarm_evt
);

    localparam int N  = 1 << WIN_LOG2;
    localparam int SW = 8 + WIN_LOG2;
    localparam int FW = WIN_LOG2 + 1;
    localparam int CW = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE + 1);
    localparam logic [FW-1:0] FILL_MAX = FW'(N);
    localparam logic [CW-1:0] DEB_CNT  = CW'(DEBOUNCE);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ARMING    = 2'd1,
        S_ALARM     = 2'd2,
        S_RELEASING = 2'd3
    } state_t;

    logic [7:0]    hist_q [N];
    logic [SW-1:0] sum_q, sum_d;
    logic [7:0]    avg_q, peak_q;
    logic [FW-1:0] fill_q, fill_d;
    logic          avg_valid_q, avg_upd_q;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          alarm_q, alarm_d, evt_q, evt_d;
    logic          accept, eval, qual_hi, qual_lo;

    assign accept = ena & mag_valid;
    assign sum_d  = sum_q + {{WIN_LOG2{1'b0}}, mag_in} - {{WIN_LOG2{1'b0}}, hist_q[N-1]};
    assign fill_d = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) hist_q[i] <= '0;
            sum_q       <= '0;
            avg_q       <= '0;
            peak_q      <= '0;
            fill_q      <= '0;
            avg_valid_q <= 1'b0;
            avg_upd_q   <= 1'b0;
        end else begin
            if (accept) begin
                hist_q[0] <= mag_in;
                for (int i = 1; i < N; i++) hist_q[i] <= hist_q[i-1];
                sum_q       <= sum_d;
                avg_q       <= sum_d[SW-1:WIN_LOG2];
                fill_q      <= fill_d;
                avg_valid_q <= avg_valid_q | (fill_d == FILL_MAX);
            end
            // A pending update survives ena=0 so the evaluation is only deferred.
            if (ena) begin
                avg_upd_q <= accept;
                if (clear_peak)
                    peak_q <= mag_valid ? mag_in : 8'd0;
                else if (mag_valid && (mag_in > peak_q))
                    peak_q <= mag_in;
            end
        end
    end

    assign eval    = ena & avg_upd_q & avg_valid_q;
    assign qual_hi = (avg_q >= thresh_hi);
    assign qual_lo = (avg_q <  thresh_lo);
    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (eval) begin
            case (state_q)
                S_IDLE: begin
                    if (qual_hi) begin
                        if (DEBOUNCE == 1) begin
                            state_d = S_ALARM;
                            cnt_d   = '0;
                        end else begin
                            state_d = S_ARMING;
                            cnt_d   = CW'(1);
                        end
                    end
                end
                S_ARMING: begin
                    if (!qual_hi) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_inc == DEB_CNT) begin
                        state_d = S_ALARM;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_inc;
                    end
                end
                S_ALARM: begin
                    if (qual_lo) begin
                        if (DEBOUNCE == 1) begin
                            state_d = S_IDLE;
                            cnt_d   = '0;
                        end else begin
                            state_d = S_RELEASING;
                            cnt_d   = CW'(1);
                        end
                    end
                end
                default: begin
                    if (!qual_lo) begin
                        state_d = S_ALARM;
                        cnt_d   = '0;
                    end else if (cnt_inc == DEB_CNT) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_inc;
                    end
                end
            endcase
        end
        alarm_d = (state_d == S_ALARM) || (state_d == S_RELEASING);
        evt_d   = alarm_d ^ alarm_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            alarm_q <= 1'b0;
            evt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            alarm_q <= alarm_d;
            evt_q   <= evt_d;
        end
    end

    assign avg_out   = avg_q;
    assign avg_valid = avg_valid_q;
    assign peak_out  = peak_q;
    assign alarm     = alarm_q;
    assign alarm_evt = evt_q;

endmodule
`default_nettype wire

// File: tb/tb_mag_alarm_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_mag_alarm_monitor
// Purpose  : Directed scoreboard bench for mag_alarm_monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mag_alarm_monitor;

    localparam int WL  = 3;
    localparam int DEB = 4;
    localparam int N   = 1 << WL;

    logic       clk = 1'b0, rst_n = 1'b0, ena = 1'b0, mag_valid = 1'b0, clear_peak = 1'b0;
    logic [7:0] mag_in = 8'd0, thresh_hi = 8'd100, thresh_lo = 8'd60;
    logic [7:0] avg_out, peak_out;
    logic       avg_valid, alarm, alarm_evt;

    mag_alarm_monitor #(.WIN_LOG2(WL), .DEBOUNCE(DEB)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .mag_in(mag_in), .mag_valid(mag_valid),
        .thresh_hi(thresh_hi), .thresh_lo(thresh_lo), .clear_peak(clear_peak),
        .avg_out(avg_out), .avg_valid(avg_valid), .peak_out(peak_out),
        .alarm(alarm), .alarm_evt(alarm_evt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    avg;
        int    vld;
        int    peak;
        int    alm;
        int    evt;
        string tag;
    } exp_t;
    exp_t sbq[$];

    int m_hist [N];
    int m_fill, m_avg, m_vld, m_peak, m_upd, m_alarm, m_run, m_evt;
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        foreach (m_hist[i]) m_hist[i] = 0;
        m_fill = 0; m_avg = 0; m_vld = 0; m_peak = 0;
        m_upd = 0; m_alarm = 0; m_run = 0; m_evt = 0;
    endtask

    // Reference behaviour for one clock edge, using pre-edge state for evaluation.
    task automatic model_edge(input bit e, input bit v, input int m, input bit c);
        int s;
        bit ev;
        ev    = e && (m_upd != 0) && (m_vld != 0);
        m_evt = 0;
        if (ev) begin
            if (m_alarm == 0) begin
                m_run = (m_avg >= int'(thresh_hi)) ? m_run + 1 : 0;
                if (m_run == DEB) begin m_alarm = 1; m_run = 0; m_evt = 1; end
            end else begin
                m_run = (m_avg < int'(thresh_lo)) ? m_run + 1 : 0;
                if (m_run == DEB) begin m_alarm = 0; m_run = 0; m_evt = 1; end
            end
        end
        if (e && v) begin
            for (int i = N - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = m;
            s = 0;
            foreach (m_hist[i]) s += m_hist[i];
            m_avg = s / N;
            if (m_fill < N) m_fill++;
            m_vld = (m_fill == N) ? 1 : 0;
        end
        if (e) begin
            if (c)                 m_peak = v ? m : 0;
            else if (v && m > m_peak) m_peak = m;
            m_upd = v ? 1 : 0;
        end
    endtask

    task automatic check_out();
        exp_t x;
        if (sbq.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        x = sbq.pop_front();
        chk({x.tag, ".avg"},   32'(avg_out),   32'(x.avg));
        chk({x.tag, ".vld"},   32'(avg_valid), 32'(x.vld));
        chk({x.tag, ".peak"},  32'(peak_out),  32'(x.peak));
        chk({x.tag, ".alarm"}, 32'(alarm),     32'(x.alm));
        chk({x.tag, ".evt"},   32'(alarm_evt), 32'(x.evt));
    endtask

    task automatic step(input bit e, input bit v, input int m, input bit c, input string tag);
        exp_t x;
        ena = e; mag_valid = v; mag_in = 8'(m); clear_peak = c;
        @(posedge clk);
        model_edge(e, v, m, c);
        x.avg = m_avg; x.vld = m_vld; x.peak = m_peak;
        x.alm = m_alarm; x.evt = m_evt; x.tag = tag;
        sbq.push_back(x);
        #1;
        check_out();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".avg"},   32'(avg_out),   32'd0);
        chk({tag, ".vld"},   32'(avg_valid), 32'd0);
        chk({tag, ".peak"},  32'(peak_out),  32'd0);
        chk({tag, ".alarm"}, 32'(alarm),     32'd0);
        chk({tag, ".evt"},   32'(alarm_evt), 32'd0);
    endtask

    initial begin
        int guard;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) step(1, 1, 40, 0, "fill40");
        chk("fill40_final_avg", 32'(avg_out), 32'd40);
        chk("fill40_final_vld", 32'(avg_valid), 32'd1);

        for (int i = 0; i < 8; i++) step(1, 1, 0, 0, "fill0");
        for (int i = 0; i < 7; i++) step(1, 1, 200, 0, "rise200");
        chk("rise_pre_alarm", 32'(alarm), 32'd0);
        step(1, 1, 200, 0, "rise200_edge");
        chk("rise_alarm", 32'(alarm), 32'd1);
        chk("rise_evt", 32'(alarm_evt), 32'd1);
        step(1, 0, 0, 0, "rise_idle");

        for (int i = 0; i < 12; i++) step(1, 1, 0, 0, "release0");
        chk("release_done", 32'(alarm), 32'd0);

        for (int i = 0; i < 10; i++) step(1, 1, 200, 0, "rearm200");
        for (int i = 0; i < 7; i++) step(1, 1, 0, 0, "rel_part");
        step(1, 1, 255, 0, "rel_glitch_a");
        step(1, 1, 255, 0, "rel_glitch_b");
        step(1, 0, 0, 0, "rel_glitch_eval");
        chk("glitch_alarm_held", 32'(alarm), 32'd1);
        for (int i = 0; i < 14; i++) step(1, 1, 0, 0, "rel_final");

        step(1, 0, 0, 1, "peak_clr0");
        step(1, 1, 10, 0, "peak10");
        step(1, 1, 250, 0, "peak250");
        step(1, 1, 30, 0, "peak30");
        step(1, 0, 0, 1, "peak_clear");
        step(1, 1, 7, 1, "peak_clear_sample");
        chk("peak_is7", 32'(peak_out), 32'd7);

        step(1, 1, 100, 0, "ena_pre");
        for (int i = 0; i < 5; i++) step(0, 1, 255, 1, "ena_off");
        step(1, 0, 0, 0, "ena_back");
        step(1, 1, 50, 0, "defer_sample");
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, "defer_hold");
        step(1, 0, 0, 0, "defer_eval");

        guard = 0;
        while (m_run != 2 && guard < 40) begin
            step(1, 1, 200, 0, "arming200");
            guard++;
        end
        chk("arming_reached", 32'(m_run), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) step(1, 1, 120, 0, "refill");
        chk("refill_valid", 32'(avg_valid), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
